// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit.
package mem_access_unit_pkg;

  // Bit positions inside the mem_signals control bundle
  localparam int unsigned MS_SIGN    = 5;
  localparam int unsigned MS_READ    = 4;
  localparam int unsigned MS_WRITE   = 3;
  localparam int unsigned MS_SIZE_HI = 2;
  localparam int unsigned MS_SIZE_LO = 0;

  localparam int unsigned NB_WORD = 32;
  localparam int unsigned NB_BE   = 4;
  localparam int unsigned NB_OFF  = 2;
  localparam int unsigned NB_SIZE = 3;

  localparam logic [NB_SIZE-1:0] SZ_WORD = 3'b100;
  localparam logic [NB_SIZE-1:0] SZ_HALF = 3'b010;
  localparam logic [NB_SIZE-1:0] SZ_BYTE = 3'b001;

  localparam logic [NB_BE-1:0] BE_NONE    = 4'b0000;
  localparam logic [NB_BE-1:0] BE_BYTE0   = 4'b0001;
  localparam logic [NB_BE-1:0] BE_HALF_LO = 4'b0011;
  localparam logic [NB_BE-1:0] BE_HALF_HI = 4'b1100;
  localparam logic [NB_BE-1:0] BE_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Exactly one of the three legal size encodings
  function automatic logic size_legal(input logic [NB_SIZE-1:0] sz);
    return (sz == SZ_WORD) || (sz == SZ_HALF) || (sz == SZ_BYTE);
  endfunction

  // Half on an odd byte or word off a word boundary
  function automatic logic is_misaligned(input logic [NB_SIZE-1:0] sz,
                                         input logic [NB_OFF-1:0]  off);
    return ((sz == SZ_HALF) && off[0]) || ((sz == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data/enables into lanes, load data out of lanes.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [NB_WORD-1:0] st_data,
  input  logic [NB_SIZE-1:0] st_size,
  input  logic [NB_OFF-1:0]  st_off,
  output logic [NB_WORD-1:0] wdata_c,
  output logic [NB_BE-1:0]   be_c,
  input  logic [NB_WORD-1:0] ld_rdata,
  input  logic [NB_SIZE-1:0] ld_size,
  input  logic [NB_OFF-1:0]  ld_off,
  input  logic               ld_sign,
  output logic [NB_WORD-1:0] load_data_c
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: replicate data across lanes, enable only the addressed ones
  always_comb begin
    wdata_c = st_data;
    be_c    = BE_WORD;
    case (st_size)
      SZ_BYTE: begin
        wdata_c = {4{st_data[7:0]}};
        be_c    = BE_BYTE0 << st_off;
      end
      SZ_HALF: begin
        wdata_c = {2{st_data[15:0]}};
        be_c    = st_off[1] ? BE_HALF_HI : BE_HALF_LO;
      end
      default: begin
        wdata_c = st_data;
        be_c    = BE_WORD;
      end
    endcase
  end

  // Load side: pick the addressed lane and sign/zero extend it
  always_comb begin
    ld_byte     = ld_rdata[8*ld_off +: 8];
    ld_half     = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    load_data_c = ld_rdata;
    case (ld_size)
      SZ_BYTE: load_data_c = ld_sign ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
      SZ_HALF: load_data_c = ld_sign ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
      default: load_data_c = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller with req/ack handshake and timeout.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ADDR = 10,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [5:0]         mem_signals,
  input  logic [NB_DATA-1:0] addr,
  input  logic [NB_DATA-1:0] store_data,
  input  logic [NB_DATA-1:0] dmem_rdata,
  input  logic               dmem_ack,
  output logic               stall,
  output logic               done,
  output logic [NB_DATA-1:0] load_data,
  output logic               misalign,
  output logic               bus_err,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [NB_ADDR-1:0] dmem_addr,
  output logic [NB_BE-1:0]   dmem_be,
  output logic [NB_DATA-1:0] dmem_wdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [NB_ADDR-1:0]   addr_q, addr_d;
  logic [NB_OFF-1:0]    off_q, off_d;
  logic [NB_SIZE-1:0]   size_q, size_d;
  logic                 sign_q, sign_d;
  logic [NB_BE-1:0]     be_q, be_d;
  logic [NB_DATA-1:0]   wdata_q, wdata_d;
  logic                 req_q, req_d;
  logic                 done_q, done_d;
  logic                 mis_q, mis_d;
  logic                 err_q, err_d;
  logic [NB_DATA-1:0]   load_q, load_d;

  logic [NB_SIZE-1:0]   in_size;
  logic [NB_OFF-1:0]    in_off;
  logic                 accept;
  logic [NB_DATA-1:0]   st_wdata;
  logic [NB_BE-1:0]     st_be;
  logic [NB_DATA-1:0]   ld_ext;
  logic                 unused_addr_hi;

  assign in_size        = mem_signals[MS_SIZE_HI:MS_SIZE_LO];
  assign in_off         = addr[1:0];
  assign accept         = req_valid && (mem_signals[MS_READ] || mem_signals[MS_WRITE])
                          && size_legal(in_size);
  assign unused_addr_hi = ^addr[NB_DATA-1:NB_ADDR+2];

  mem_lane_align u_lane (
    .st_data     (store_data),
    .st_size     (in_size),
    .st_off      (in_off),
    .wdata_c     (st_wdata),
    .be_c        (st_be),
    .ld_rdata    (dmem_rdata),
    .ld_size     (size_q),
    .ld_off      (off_q),
    .ld_sign     (sign_q),
    .load_data_c (ld_ext)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    off_d   = off_q;
    size_d  = size_q;
    sign_d  = sign_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    req_d   = req_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    load_d  = load_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = mem_signals[MS_WRITE];
          addr_d  = addr[NB_ADDR+1:2];
          off_d   = in_off;
          size_d  = in_size;
          sign_d  = mem_signals[MS_SIGN];
          be_d    = st_be;
          wdata_d = st_wdata;
          cnt_d   = '0;
          if (is_misaligned(in_size, in_off)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
            load_d  = '0;
          end else begin
            state_d = ST_ACCESS;
            req_d   = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_ack) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          load_d  = we_q ? '0 : ld_ext;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          load_d  = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and request registers; reset abandons any outstanding access
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      be_q    <= BE_NONE;
      wdata_q <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      load_q  <= load_d;
    end
  end

  // Stall is combinational so the accept cycle itself freezes the pipeline
  assign stall      = reset && (((state_q == ST_IDLE) && accept) || (state_q == ST_ACCESS));
  assign done       = done_q;
  assign misalign   = mis_q;
  assign bus_err    = err_q;
  assign load_data  = load_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic [5:0]  mem_signals;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        misalign;
  logic        bus_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [9:0]  dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;

  int unsigned n_assert;
  int unsigned n_fail;
  int unsigned req_cycles;

  // mem_signals encodings: {sign, read, write, size[2:0]}
  localparam logic [5:0] OP_SB  = 6'b001001;
  localparam logic [5:0] OP_SW  = 6'b001100;
  localparam logic [5:0] OP_LB  = 6'b110001;
  localparam logic [5:0] OP_LBU = 6'b010001;
  localparam logic [5:0] OP_LH  = 6'b110010;
  localparam logic [5:0] OP_LHU = 6'b010010;
  localparam logic [5:0] OP_LW  = 6'b010100;

  mem_access_unit #(.NB_DATA(32), .NB_ADDR(10), .TIMEOUT(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .mem_signals (mem_signals),
    .addr        (addr),
    .store_data  (store_data),
    .dmem_rdata  (dmem_rdata),
    .dmem_ack    (dmem_ack),
    .stall       (stall),
    .done        (done),
    .load_data   (load_data),
    .misalign    (misalign),
    .bus_err     (bus_err),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one request, ack after wait_cyc idle ACCESS cycles; returns in the DONE cycle
  task automatic run_op(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rd, input int unsigned wait_cyc);
    req_valid   = 1'b1;
    mem_signals = sig;
    addr        = a;
    store_data  = sd;
    step();
    repeat (wait_cyc) step();
    dmem_ack   = 1'b1;
    dmem_rdata = rd;
    step();
    dmem_ack  = 1'b0;
    req_valid = 1'b0;
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    reset       = 1'b0;
    req_valid   = 1'b0;
    mem_signals = '0;
    addr        = '0;
    store_data  = '0;
    dmem_rdata  = '0;
    dmem_ack    = 1'b0;
    step();
    step();
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_req", dmem_req, 0);
    check("rst_load", load_data, 0);
    @(negedge clock);
    reset = 1'b1;
    step();

    // Ack while idle is ignored
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    check("idle_ack_done", done, 0);
    check("idle_ack_req", dmem_req, 0);

    // SB to 0x13: lane 3, ack after two ACCESS cycles
    req_valid = 1'b1; mem_signals = OP_SB; addr = 32'h13; store_data = 32'hA5;
    #1;
    check("sb_stall_accept", stall, 1);
    step();
    check("sb_req", dmem_req, 1);
    check("sb_we", dmem_we, 1);
    check("sb_addr", 32'(dmem_addr), 4);
    check("sb_be", 32'(dmem_be), 32'h8);
    check("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    check("sb_stall_acc1", stall, 1);
    step();
    dmem_ack = 1'b1;
    #1;
    check("sb_stall_acc2", stall, 1);
    check("sb_req_held", dmem_req, 1);
    step();
    dmem_ack = 1'b0; req_valid = 1'b0;
    check("sb_done", done, 1);
    check("sb_stall_done", stall, 0);
    check("sb_req_drop", dmem_req, 0);
    check("sb_no_err", bus_err, 0);
    step();
    check("sb_done_pulse", done, 0);

    // Loads with lane extraction
    run_op(OP_LB, 32'h103, 32'h0, 32'h80112233, 0);
    check("lb_done", done, 1);
    check("lb_load", load_data, 32'hFFFFFF80);
    check("lb_we", dmem_we, 0);
    step();
    run_op(OP_LBU, 32'h103, 32'h0, 32'h80112233, 1);
    check("lbu_load", load_data, 32'h00000080);
    step();
    run_op(OP_LB, 32'h101, 32'h0, 32'h80112233, 0);
    check("lb_off1_load", load_data, 32'h00000022);
    step();
    run_op(OP_LH, 32'h102, 32'h0, 32'hBEEF1234, 0);
    check("lh_load", load_data, 32'hFFFFBEEF);
    step();
    check("load_hold", load_data, 32'hFFFFBEEF);
    run_op(OP_LHU, 32'h100, 32'h0, 32'hBEEF1234, 2);
    check("lhu_load", load_data, 32'h00001234);
    step();
    run_op(OP_LW, 32'h200, 32'h0, 32'hDEADBEEF, 0);
    check("lw_load", load_data, 32'hDEADBEEF);
    check("lw_addr", 32'(dmem_addr), 32'h80);
    step();

    // Misaligned LW: straight to DONE, no request
    req_valid = 1'b1; mem_signals = OP_LW; addr = 32'h1;
    #1;
    check("mis_stall_accept", stall, 1);
    step();
    req_valid = 1'b0;
    check("mis_done", done, 1);
    check("mis_flag", misalign, 1);
    check("mis_req", dmem_req, 0);
    check("mis_load", load_data, 0);
    check("mis_stall", stall, 0);
    step();
    check("mis_pulse", misalign, 0);

    // No ack: request held TIMEOUT cycles, then bus error
    run_op(OP_LW, 32'h200, 32'h0, 32'hDEADBEEF, 0);
    step();
    req_valid = 1'b1; mem_signals = OP_LW; addr = 32'h10;
    step();
    req_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      if (dmem_req && !done) req_cycles++;
      step();
    end
    req_valid = 1'b0;
    check("to_req_cycles", req_cycles, 16);
    check("to_done", done, 1);
    check("to_err", bus_err, 1);
    check("to_req_drop", dmem_req, 0);
    check("to_load", load_data, 0);
    step();
    check("to_err_pulse", bus_err, 0);

    // Back-to-back LW then SW with req_valid held
    req_valid = 1'b1; mem_signals = OP_LW; addr = 32'h20;
    step();
    dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D;
    step();
    dmem_ack = 1'b0;
    check("b2b_lw_done", done, 1);
    check("b2b_lw_load", load_data, 32'h0BADF00D);
    check("b2b_done_stall", stall, 0);
    check("b2b_done_noreq", dmem_req, 0);
    mem_signals = OP_SW; addr = 32'h24; store_data = 32'h12345678;
    step();
    check("b2b_idle_noreq", dmem_req, 0);
    check("b2b_sw_stall", stall, 1);
    step();
    check("b2b_sw_req", dmem_req, 1);
    check("b2b_sw_we", dmem_we, 1);
    check("b2b_sw_addr", 32'(dmem_addr), 9);
    check("b2b_sw_be", 32'(dmem_be), 32'hF);
    check("b2b_sw_wdata", dmem_wdata, 32'h12345678);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0; req_valid = 1'b0;
    check("b2b_sw_done", done, 1);
    step();

    // Reset in the middle of an outstanding access
    run_op(OP_LW, 32'h30, 32'h0, 32'h11111111, 0);
    step();
    req_valid = 1'b1; mem_signals = OP_LW; addr = 32'h40;
    step();
    check("mid_req_before", dmem_req, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_req_reset", dmem_req, 0);
    check("mid_stall_reset", stall, 0);
    check("mid_load_reset", load_data, 0);
    check("mid_addr_reset", 32'(dmem_addr), 0);
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    step();
    check("post_rst_stall", stall, 0);
    check("post_rst_req", dmem_req, 0);
    run_op(OP_LW, 32'h44, 32'h0, 32'hCAFEF00D, 1);
    check("post_rst_done", done, 1);
    check("post_rst_load", load_data, 32'hCAFEF00D);
    check("post_rst_addr", 32'(dmem_addr), 32'h11);
    step();
    check("post_rst_idle", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
